// File: rtl/spi_mstr.sv
// SPI master, mode 0, 16-bit words, five decoded active-low slave selects.
// Define SPI_LOOPBACK_EN to receive from MOSI instead of MISO.
module spi_mstr #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt_SPI,
    input  logic [15:0] SPI_data,
    input  logic [2:0]  ss,
    output logic        SPI_done,
    output logic [7:0]  EEP_data,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        trig_ss_n,
    output logic        ch1_ss_n,
    output logic        ch2_ss_n,
    output logic        ch3_ss_n,
    output logic        EEP_ss_n
);

    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(SCLK_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(SCLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [15:0]     shft_q;
    logic            smp_q;
    logic            sclk_q;
    logic            done_q;
    logic [7:0]      eep_q;
    logic [4:0]      ss_n_q;
    logic            rx_bit;

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = shft_q[15];
`else
    assign rx_bit = MISO;
`endif

    // Slave code to select vector {EEP, ch3, ch2, ch1, trig}; unused codes select nobody.
    function automatic logic [4:0] ss_dec(input logic [2:0] code);
        logic [4:0] v;
        v = 5'b11111;
        case (code)
            3'b000:  v = 5'b11110;
            3'b001:  v = 5'b11101;
            3'b010:  v = 5'b11011;
            3'b011:  v = 5'b10111;
            3'b100:  v = 5'b01111;
            default: v = 5'b11111;
        endcase
        return v;
    endfunction

    // Transaction sequencer: framing, SCLK generation, shift/sample and completion.
    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shft_q    <= '0;
            smp_q     <= 1'b0;
            sclk_q    <= 1'b0;
            eep_q     <= '0;
            ss_n_q    <= 5'b11111;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wrt_SPI) begin
                        shft_q    <= SPI_data;
                        ss_n_q    <= ss_dec(ss);
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= FRONT;
                    end
                end
                FRONT: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == HALF_M1) begin
                        sclk_q <= 1'b1;
                        smp_q  <= rx_bit;
                        cnt_q  <= cnt_q + 1'b1;
                    end else if (cnt_q == LAST) begin
                        sclk_q    <= 1'b0;
                        shft_q    <= {shft_q[14:0], smp_q};
                        cnt_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 4'd15) begin
                            state_q <= BACK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BACK: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        ss_n_q  <= 5'b11111;
                        eep_q   <= shft_q[7:0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    sclk_q  <= 1'b0;
                    ss_n_q  <= 5'b11111;
                end
            endcase
        end
    end

    assign SPI_done  = done_q;
    assign EEP_data  = eep_q;
    assign SCLK      = sclk_q;
    assign MOSI      = shft_q[15];
    assign trig_ss_n = ss_n_q[0];
    assign ch1_ss_n  = ss_n_q[1];
    assign ch2_ss_n  = ss_n_q[2];
    assign ch3_ss_n  = ss_n_q[3];
    assign EEP_ss_n  = ss_n_q[4];

endmodule

// File: tb/tb_spi_mstr.sv
// Directed testbench for spi_mstr: framing, timing, selects, abort, back-to-back.
// A mode-0 slave model drives MISO and captures MOSI.
module tb_spi_mstr;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrt_SPI;
    logic [15:0] SPI_data;
    logic [2:0]  ss;
    logic        SPI_done;
    logic [7:0]  EEP_data;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int done_cnt = 0;

    logic [15:0] slv;
    logic [15:0] mosi_cap;
    logic [4:0]  ssv;

    spi_mstr #(.SCLK_DIV(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wrt_SPI   (wrt_SPI),
        .SPI_data  (SPI_data),
        .ss        (ss),
        .SPI_done  (SPI_done),
        .EEP_data  (EEP_data),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .trig_ss_n (trig_ss_n),
        .ch1_ss_n  (ch1_ss_n),
        .ch2_ss_n  (ch2_ss_n),
        .ch3_ss_n  (ch3_ss_n),
        .EEP_ss_n  (EEP_ss_n)
    );

    always #5 clk = ~clk;

    assign ssv  = {EEP_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n, trig_ss_n};
    assign MISO = slv[15];

    always @(negedge SCLK) slv = {slv[14:0], 1'b0};
    always @(posedge SCLK) mosi_cap = {mosi_cap[14:0], MOSI};
    always @(posedge clk) if (SPI_done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Starts at a negedge; returns at the negedge where SPI_done is seen.
    task automatic run(input logic [15:0] d, input logic [2:0] s,
                       input logic [15:0] sw, input int inj,
                       output int n, output logic [4:0] ss1);
        slv      = sw;
        mosi_cap = '0;
        wrt_SPI  = 1'b1;
        SPI_data = d;
        ss       = s;
        n        = 0;
        ss1      = 5'h00;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                wrt_SPI = 1'b0;
                ss1     = ssv;
            end
            if (inj != 0 && n == inj) begin
                wrt_SPI  = 1'b1;
                SPI_data = 16'hFFFF;
                ss       = 3'b000;
            end
            if (inj != 0 && n == inj + 1) wrt_SPI = 1'b0;
            if (SPI_done) break;
        end
    endtask

    int          n;
    int          d0;
    logic [4:0]  s1;
    logic [7:0]  exp_eep;

    initial begin
        rst      = 1'b1;
        wrt_SPI  = 1'b0;
        SPI_data = '0;
        ss       = '0;
        slv      = '0;
        mosi_cap = '0;
        repeat (3) @(negedge clk);
        chk("rst_ssn",  {27'd0, ssv}, 32'h1F);
        chk("rst_sclk", {31'd0, SCLK}, 32'd0);
        chk("rst_mosi", {31'd0, MOSI}, 32'd0);
        chk("rst_done", {31'd0, SPI_done}, 32'd0);
        chk("rst_eep",  {24'd0, EEP_data}, 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // ch1 transfer, timing, MOSI order, received byte
        d0 = done_cnt;
        run(16'hA5C3, 3'b001, 16'h3C5A, 0, n, s1);
`ifdef SPI_LOOPBACK_EN
        exp_eep = 8'hC3;
`else
        exp_eep = 8'h5A;
`endif
        chk("t1_ssn",   {27'd0, s1}, 32'h1D);
        chk("t1_lat",   n, 545);
        chk("t1_mosi",  {16'd0, mosi_cap}, 32'hA5C3);
        chk("t1_eep",   {24'd0, EEP_data}, {24'd0, exp_eep});
        chk("t1_ssoff", {27'd0, ssv}, 32'h1F);
        chk("t1_sclk",  {31'd0, SCLK}, 32'd0);
        @(negedge clk);
        chk("t1_pulse", {31'd0, SPI_done}, 32'd0);
        chk("t1_ndone", done_cnt - d0, 1);

        // EEP select, then an unused code
        run(16'h0F0F, 3'b100, 16'h1234, 0, n, s1);
        chk("t2_ssn", {27'd0, s1}, 32'h0F);
        chk("t2_lat", n, 545);
        @(negedge clk);
        run(16'h5555, 3'b110, 16'hCAFE, 0, n, s1);
`ifdef SPI_LOOPBACK_EN
        exp_eep = 8'h55;
`else
        exp_eep = 8'hFE;
`endif
        chk("t3_ssn",  {27'd0, s1}, 32'h1F);
        chk("t3_lat",  n, 545);
        chk("t3_eep",  {24'd0, EEP_data}, {24'd0, exp_eep});
        @(negedge clk);

        // Request 100 cycles in is ignored
        d0 = done_cnt;
        run(16'h8001, 3'b010, 16'h00FF, 100, n, s1);
        chk("t4_ssn", {27'd0, s1}, 32'h1B);
        chk("t4_lat", n, 545);
        repeat (600) @(negedge clk);
        chk("t4_ndone", done_cnt - d0, 1);

        // Back-to-back: accept in the SPI_done cycle
        run(16'h1111, 3'b000, 16'hAAAA, 0, n, s1);
        chk("t5a_ssn", {27'd0, s1}, 32'h1E);
        run(16'h2222, 3'b011, 16'h5A5A, 0, n, s1);
`ifdef SPI_LOOPBACK_EN
        exp_eep = 8'h22;
`else
        exp_eep = 8'h5A;
`endif
        chk("t5b_ssn", {27'd0, s1}, 32'h17);
        chk("t5b_lat", n, 545);
        chk("t5b_eep", {24'd0, EEP_data}, {24'd0, exp_eep});
        @(negedge clk);

        // Reset abort at cycle 300; request during reset ignored
        d0 = done_cnt;
        slv      = 16'hFFFF;
        wrt_SPI  = 1'b1;
        SPI_data = 16'hF00F;
        ss       = 3'b001;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 1) wrt_SPI = 1'b0;
        end
        rst     = 1'b1;
        wrt_SPI = 1'b1;
        @(negedge clk);
        chk("t6_ssn",  {27'd0, ssv}, 32'h1F);
        chk("t6_sclk", {31'd0, SCLK}, 32'd0);
        chk("t6_eep",  {24'd0, EEP_data}, 32'h00);
        chk("t6_done", {31'd0, SPI_done}, 32'd0);
        rst     = 1'b0;
        wrt_SPI = 1'b0;
        @(negedge clk);
        chk("t6_idle", {27'd0, ssv}, 32'h1F);
        repeat (600) @(negedge clk);
        chk("t6_ndone", done_cnt - d0, 0);

        // Loopback-sensitive case: MISO held high
        run(16'h12F0, 3'b100, 16'hFFFF, 0, n, s1);
`ifdef SPI_LOOPBACK_EN
        exp_eep = 8'hF0;
`else
        exp_eep = 8'hFF;
`endif
        chk("t7_eep", {24'd0, EEP_data}, {24'd0, exp_eep});
        chk("t7_lat", n, 545);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
